insight_tl_b_tracer: RTL and testbench

- Parametrised, buffered trace capture for one TileLink B (probe) channel of a hart: passively snoops the channel handshake, tags multi-beat bursts, filters by opcode and pushes timestamped records into a FIFO drained by a valid/ready trace sink.
- Sits beside the hart's B-channel insight bundle; it never drives the monitored channel.
- Adds event counters and overflow accounting.

---
 rtl/insight_tl_b_tracer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_insight_tl_b_tracer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insight_tl_b_tracer.sv
// insight_tl_b_tracer
// -------------------
// Passive trace capture for one TileLink B (probe) channel. The block snoops the
// b_valid/b_ready handshake and never drives the monitored channel. It tags each
// beat with its position in a burst (first/last), filters by opcode, and pushes
// timestamped records into a FIFO that a trace sink drains.
//
// Optional feature macro: INSIGHT_B_TRACE_DATA_EN
//   defined   : b_mask, b_data and b_corrupt are stored per FIFO entry.
//   undefined : those fields are not stored; trace_mask/data/corrupt read 0.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid & ready are both high. The monitored side is observe-only. On the
// sink side, trace_valid and all trace_* fields hold steady until the record is
// taken (trace_valid & trace_ready).
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   b_*                   : monitored B-channel handshake and fields (inputs)
//   enable                : capture enable (counters also gated by it)
//   clear                 : synchronous flush of FIFO, counters, overflow
//   opcode_en[7:0]        : bit i enables capture of opcode i
//   trace_valid/ready     : sink handshake
//   trace_*               : FIFO head record
//   fire_count            : beats fired while enabled (wraps)
//   stall_count           : cycles with b_valid & !b_ready while enabled (wraps)
//   drop_count            : captured beats lost to a full FIFO (saturates)
//   overflow              : sticky, set by any drop
//   tracker_state         : beat tracker state (0 = IDLE, 1 = BURST)

module insight_tl_b_tracer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 3,
    parameter int SIZE_W = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                b_valid,
    input  logic                b_ready,
    input  logic [2:0]          b_opcode,
    input  logic [1:0]          b_param,
    input  logic [SIZE_W-1:0]   b_size,
    input  logic [SRC_W-1:0]    b_source,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_mask,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                b_corrupt,
    input  logic                enable,
    input  logic                clear,
    input  logic [7:0]          opcode_en,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [2:0]          trace_opcode,
    output logic [1:0]          trace_param,
    output logic [SIZE_W-1:0]   trace_size,
    output logic [SRC_W-1:0]    trace_source,
    output logic [ADDR_W-1:0]   trace_address,
    output logic [DATA_W/8-1:0] trace_mask,
    output logic [DATA_W-1:0]   trace_data,
    output logic                trace_corrupt,
    output logic                trace_first,
    output logic                trace_last,
    output logic                trace_lost,
    output logic [TS_W-1:0]     trace_ts,
    output logic [31:0]         fire_count,
    output logic [31:0]         stall_count,
    output logic [15:0]         drop_count,
    output logic                overflow,
    output logic                tracker_state
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int LG_BYTES = $clog2(MASK_W);
    localparam int MAX_SIZE = (1 << SIZE_W) - 1;
    // Wide enough to hold the largest beat count 2^(MAX_SIZE-LG_BYTES).
    localparam int BEAT_W   = (MAX_SIZE > LG_BYTES) ? (MAX_SIZE - LG_BYTES + 1) : 1;
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } trk_state_t;

    typedef struct packed {
`ifdef INSIGHT_B_TRACE_DATA_EN
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
        logic              corrupt;
`endif
        logic [2:0]        opcode;
        logic [1:0]        param;
        logic [SIZE_W-1:0] size;
        logic [SRC_W-1:0]  source;
        logic [ADDR_W-1:0] address;
        logic              first;
        logic              last;
        logic              lost;
        logic [TS_W-1:0]   ts;
    } rec_t;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic fire, capture, pop, push, drop, full;

    assign fire    = b_valid & b_ready;
    assign capture = fire & enable & opcode_en[b_opcode];

    // ------------------------------------------------------------------
    // Beat tracker: runs on every fire, independent of enable/filter/clear
    // ------------------------------------------------------------------
    trk_state_t        state, state_nxt;
    logic [BEAT_W-1:0] remain, remain_nxt;
    logic [BEAT_W-1:0] burst_beats;
    logic              beat_first, beat_last;

    // Data opcodes (0-3) span 2^size bytes, at least one beat.
    always_comb begin
        burst_beats = BEAT_W'(1);
        if (!b_opcode[2] && (b_size > SIZE_W'(LG_BYTES)))
            burst_beats = BEAT_W'(1) << (b_size - SIZE_W'(LG_BYTES));
    end

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        beat_first = 1'b0;
        beat_last  = 1'b0;
        if (fire) begin
            case (state)
                IDLE: begin
                    beat_first = 1'b1;
                    if (burst_beats == BEAT_W'(1)) begin
                        beat_last = 1'b1;
                    end else begin
                        remain_nxt = burst_beats - BEAT_W'(1);
                        state_nxt  = BURST;
                    end
                end
                BURST: begin
                    remain_nxt = remain - BEAT_W'(1);
                    if (remain == BEAT_W'(1)) begin
                        beat_last = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            remain <= '0;
        end else begin
            state  <= state_nxt;
            remain <= remain_nxt;
        end
    end

    assign tracker_state = (state == BURST);

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    rec_t             mem [DEPTH];
    rec_t             rec_in, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [TS_W-1:0]  ts_cnt;
    logic             lost_pending;

    assign pop  = trace_valid & trace_ready;
    assign full = (count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = capture & !clear & (!full | pop);
    assign drop = capture & !clear & full & !pop;

    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        rec_in         = '0;
`ifdef INSIGHT_B_TRACE_DATA_EN
        rec_in.mask    = b_mask;
        rec_in.data    = b_data;
        rec_in.corrupt = b_corrupt;
`endif
        rec_in.opcode  = b_opcode;
        rec_in.param   = b_param;
        rec_in.size    = b_size;
        rec_in.source  = b_source;
        rec_in.address = b_address;
        rec_in.first   = beat_first;
        rec_in.last    = beat_last;
        rec_in.lost    = lost_pending;
        rec_in.ts      = ts_cnt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            trace_valid  <= 1'b0;
            lost_pending <= 1'b0;
            ts_cnt       <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                trace_valid  <= 1'b0;
                lost_pending <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= rec_in;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count       <= count_nxt;
                trace_valid <= (count_nxt != '0);
                if (push)      lost_pending <= 1'b0;
                else if (drop) lost_pending <= 1'b1;
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign trace_opcode  = head.opcode;
    assign trace_param   = head.param;
    assign trace_size    = head.size;
    assign trace_source  = head.source;
    assign trace_address = head.address;
    assign trace_first   = head.first;
    assign trace_last    = head.last;
    assign trace_lost    = head.lost;
    assign trace_ts      = head.ts;
`ifdef INSIGHT_B_TRACE_DATA_EN
    assign trace_mask    = head.mask;
    assign trace_data    = head.data;
    assign trace_corrupt = head.corrupt;
`else
    assign trace_mask    = '0;
    assign trace_data    = '0;
    assign trace_corrupt = 1'b0;
    logic unused_data;
    assign unused_data = ^{b_mask, b_data, b_corrupt};
`endif

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fire_count  <= '0;
            stall_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            fire_count  <= '0;
            stall_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (fire & enable)                fire_count  <= fire_count + 32'd1;
            if (b_valid & !b_ready & enable)  stall_count <= stall_count + 32'd1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            if (drop)                         overflow    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_insight_tl_b_tracer.sv
module tb_insight_tl_b_tracer;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int SRC_W  = 3;
  localparam int SIZE_W = 4;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int MASK_W = DATA_W / 8;
  localparam int REC_W  = 3 + 2 + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W + 1 + 3 + TS_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic                b_valid = 0, b_ready = 0, b_corrupt = 0;
  logic [2:0]          b_opcode = 0;
  logic [1:0]          b_param = 0;
  logic [SIZE_W-1:0]   b_size = 0;
  logic [SRC_W-1:0]    b_source = 0;
  logic [ADDR_W-1:0]   b_address = 0;
  logic [MASK_W-1:0]   b_mask = 0;
  logic [DATA_W-1:0]   b_data = 0;
  logic                enable = 0, clear = 0, trace_ready = 0;
  logic [7:0]          opcode_en = 0;

  logic                trace_valid, trace_corrupt, trace_first, trace_last, trace_lost;
  logic [2:0]          trace_opcode;
  logic [1:0]          trace_param;
  logic [SIZE_W-1:0]   trace_size;
  logic [SRC_W-1:0]    trace_source;
  logic [ADDR_W-1:0]   trace_address;
  logic [MASK_W-1:0]   trace_mask;
  logic [DATA_W-1:0]   trace_data;
  logic [TS_W-1:0]     trace_ts;
  logic [31:0]         fire_count, stall_count;
  logic [15:0]         drop_count;
  logic                overflow, tracker_state;

  insight_tl_b_tracer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W),
    .SIZE_W(SIZE_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_param(b_param),
    .b_size(b_size), .b_source(b_source), .b_address(b_address),
    .b_mask(b_mask), .b_data(b_data), .b_corrupt(b_corrupt),
    .enable(enable), .clear(clear), .opcode_en(opcode_en),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_opcode(trace_opcode), .trace_param(trace_param), .trace_size(trace_size),
    .trace_source(trace_source), .trace_address(trace_address),
    .trace_mask(trace_mask), .trace_data(trace_data), .trace_corrupt(trace_corrupt),
    .trace_first(trace_first), .trace_last(trace_last), .trace_lost(trace_lost),
    .trace_ts(trace_ts), .fire_count(fire_count), .stall_count(stall_count),
    .drop_count(drop_count), .overflow(overflow), .tracker_state(tracker_state)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [REC_W-1:0] exp_q[$];
  logic [31:0]      m_fire, m_stall;
  logic [15:0]      m_drop;
  logic             m_ovf, m_lost;
  logic [TS_W-1:0]  m_ts;
  int               m_rem;   // beats still owed by the current burst
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fire = 0; m_stall = 0; m_drop = 0; m_ovf = 0; m_lost = 0; m_ts = 0; m_rem = 0;
  endtask

  function automatic int beats_of(input logic [2:0] op, input logic [SIZE_W-1:0] sz);
    int n;
    if (op >= 4) return 1;
    n = (1 << sz) / MASK_W;
    return (n < 1) ? 1 : n;
  endfunction

  // One clock cycle: inputs already driven; check handshake now, model the
  // posedge, then check registered outputs at the following negedge.
  task automatic step();
    logic             pop_now, fire, cap, full, f, l;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] obs;
    pop_now = (exp_q.size() != 0) && trace_ready;
    if (pop_now) begin
      obs = {trace_opcode, trace_param, trace_size, trace_source, trace_address,
             trace_mask, trace_data, trace_corrupt, trace_first, trace_last,
             trace_lost, trace_ts};
      chk("record", obs, exp_q[0]);
    end
    @(posedge clock);
    if (reset_n) begin
      fire = b_valid & b_ready;
      f = 0; l = 0;
      if (fire) begin
        if (m_rem == 0) begin
          f = 1;
          m_rem = beats_of(b_opcode, b_size);
        end
        m_rem--;
        l = (m_rem == 0);
      end
      cap = fire & enable & opcode_en[b_opcode];
      if (clear) begin
        exp_q.delete();
        m_fire = 0; m_stall = 0; m_drop = 0; m_ovf = 0; m_lost = 0;
      end else begin
        if (fire && enable) m_fire++;
        if (b_valid && !b_ready && enable) m_stall++;
        full = (exp_q.size() == DEPTH);
        if (pop_now) void'(exp_q.pop_front());
        if (cap) begin
          if (!full || pop_now) begin
`ifdef INSIGHT_B_TRACE_DATA_EN
            rec = {b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data,
                   b_corrupt, f, l, m_lost, m_ts};
`else
            rec = {b_opcode, b_param, b_size, b_source, b_address, MASK_W'(0),
                   DATA_W'(0), 1'b0, f, l, m_lost, m_ts};
`endif
            exp_q.push_back(rec);
            m_lost = 0;
          end else begin
            if (m_drop != 16'hFFFF) m_drop++;
            m_ovf = 1;
            m_lost = 1;
          end
        end
      end
      m_ts++;
    end
    @(negedge clock);
    chk("trace_valid", trace_valid, exp_q.size() != 0);
    chk("fire_count", fire_count, m_fire);
    chk("stall_count", stall_count, m_stall);
    chk("drop_count", drop_count, m_drop);
    chk("overflow", overflow, m_ovf);
    chk("tracker_state", tracker_state, m_rem != 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    b_valid = 0; b_ready = 0; clear = 0;
    step();
  endtask

  task automatic send(input logic [2:0] op, input logic [SIZE_W-1:0] sz, input logic [ADDR_W-1:0] addr);
    b_valid = 1; b_ready = 1; clear = 0;
    b_opcode = op; b_size = sz; b_address = addr;
    b_param = 2'($urandom_range(0, 3));
    b_source = SRC_W'($urandom_range(0, 7));
    b_mask = MASK_W'($urandom);
    b_data = {$urandom, $urandom};
    b_corrupt = 1'($urandom_range(0, 1));
    step();
    b_valid = 0; b_ready = 0;
  endtask

  task automatic drain(input int n);
    trace_ready = 1;
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic pulse_clear();
    b_valid = 0; b_ready = 0; clear = 1;
    step();
    clear = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {trace_valid, trace_opcode, trace_param, trace_size, trace_source,
              trace_address, trace_mask, trace_data, trace_corrupt, trace_first,
              trace_last, trace_lost, trace_ts, fire_count, stall_count,
              drop_count, overflow, tracker_state}, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    #1 check_all_zero("reset_state");
    @(negedge clock);
    reset_n = 1;
    enable = 1; opcode_en = 8'hFF; trace_ready = 0;

    // Single Probe
    send(3'd6, 4'd6, 32'h8000_1000);
    chk("probe_fire_count", fire_count, 32'd1);
    chk("probe_first_last", {trace_valid, trace_first, trace_last}, 3'b111);
    idle();
    drain(2);

    // PutFull burst of 4 beats, drained as it arrives
    trace_ready = 1;
    for (int i = 0; i < 4; i++) send(3'd0, 4'd5, 32'h100 + 32'(i * 8));
    idle();
    // Same burst filtered out, then a tagged burst again
    opcode_en = 8'hFE;
    for (int i = 0; i < 4; i++) send(3'd0, 4'd5, 32'h200 + 32'(i * 8));
    chk("filtered_empty", trace_valid, 1'b0);
    opcode_en = 8'hFF;
    trace_ready = 0;
    send(3'd0, 4'd5, 32'h300);
    chk("refire_first", {trace_first, trace_last}, 2'b10);
    for (int i = 1; i < 4; i++) send(3'd0, 4'd5, 32'h300 + 32'(i * 8));
    drain(5);

    // Overflow: 10 single-beat captures into an 8-deep FIFO
    pulse_clear();
    trace_ready = 0;
    for (int i = 0; i < 10; i++) send(3'd4, 4'd0, 32'h400 + 32'(i));
    chk("ovf_drop_count", drop_count, 16'd2);
    chk("ovf_flag", overflow, 1'b1);
    drain(9);
    trace_ready = 0;
    send(3'd5, 4'd0, 32'h500);
    chk("lost_flag", {trace_valid, trace_lost}, 2'b11);
    drain(2);

    // Full FIFO with simultaneous push and pop
    pulse_clear();
    trace_ready = 0;
    for (int i = 0; i < 8; i++) send(3'd4, 4'd0, 32'h600 + 32'(i));
    trace_ready = 1;
    send(3'd7, 4'd0, 32'h6FF);
    chk("full_pushpop_nodrop", {drop_count, overflow}, 17'd0);
    chk("full_occupancy", exp_q.size(), 8);
    drain(10);

    // Stalls and clear
    pulse_clear();
    trace_ready = 0;
    send(3'd6, 4'd0, 32'h700);
    send(3'd6, 4'd0, 32'h704);
    b_valid = 1; b_ready = 0;
    repeat (5) step();
    b_valid = 0;
    idle();
    chk("stall_count5", stall_count, 32'd5);
    pulse_clear();
    chk("clear_all", {trace_valid, fire_count, stall_count, drop_count, overflow}, '0);

    // Reset mid-burst
    send(3'd1, 4'd5, 32'h800);
    send(3'd1, 4'd5, 32'h808);
    #2 reset_n = 0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clock);
    reset_n = 1;
    trace_ready = 0;
    send(3'd1, 4'd5, 32'h900);
    chk("post_reset_first", {trace_valid, trace_first, trace_last}, 3'b110);
    for (int i = 1; i < 4; i++) send(3'd1, 4'd5, 32'h900 + 32'(i * 8));
    drain(5);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      b_valid   = ($urandom_range(0, 3) != 0);
      b_ready   = ($urandom_range(0, 2) != 0);
      b_opcode  = 3'($urandom_range(0, 7));
      b_size    = SIZE_W'($urandom_range(0, 7));
      b_param   = 2'($urandom_range(0, 3));
      b_source  = SRC_W'($urandom_range(0, 7));
      b_address = $urandom;
      b_mask    = MASK_W'($urandom);
      b_data    = {$urandom, $urandom};
      b_corrupt = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 7) != 0);
      opcode_en = 8'($urandom) | 8'($urandom);
      trace_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      step();
    end
    clear = 0; enable = 1;
    drain(DEPTH + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
